// File: rtl/complex_fsm_pkg.sv
// rtl/complex_fsm_pkg.sv - state encodings for the cola vending controller
package complex_fsm_pkg;

    localparam logic [4:0] IDLE     = 5'b00001;
    localparam logic [4:0] HALF     = 5'b00010;
    localparam logic [4:0] ONE      = 5'b00100;
    localparam logic [4:0] ONE_HALF = 5'b01000;
    localparam logic [4:0] TWO      = 5'b10000;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;

endpackage

// File: rtl/complex_fsm.sv
// rtl/complex_fsm.sv - one-hot Moore vending controller, cola at 2.5 units
module complex_fsm
    import complex_fsm_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic pi_money_one,
    input  logic pi_money_half,
    output logic po_cola,
    output logic po_money
);

    logic [4:0] state;
    logic [1:0] pi_money;
    logic [4:0] w_next_state;
    logic       w_cola;
    logic       w_money;

    assign pi_money = {pi_money_one, pi_money_half};

    // Simultaneous coins (2'b11) fall through to the hold path like 2'b00.
    always_comb begin
        w_next_state = state;
        w_cola       = 1'b0;
        w_money      = 1'b0;
        case (state)
            IDLE: begin
                if (pi_money == COIN_HALF)     w_next_state = HALF;
                else if (pi_money == COIN_ONE) w_next_state = ONE;
            end
            HALF: begin
                if (pi_money == COIN_HALF)     w_next_state = ONE;
                else if (pi_money == COIN_ONE) w_next_state = ONE_HALF;
            end
            ONE: begin
                if (pi_money == COIN_HALF)     w_next_state = ONE_HALF;
                else if (pi_money == COIN_ONE) w_next_state = TWO;
            end
            ONE_HALF: begin
                if (pi_money == COIN_HALF) begin
                    w_next_state = TWO;
                end else if (pi_money == COIN_ONE) begin
                    w_next_state = IDLE;
                    w_cola       = 1'b1;
                end
            end
            TWO: begin
                if (pi_money == COIN_HALF) begin
                    w_next_state = IDLE;
                    w_cola       = 1'b1;
                end else if (pi_money == COIN_ONE) begin
                    w_next_state = IDLE;
                    w_cola       = 1'b1;
                    w_money      = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            po_cola  <= 1'b0;
            po_money <= 1'b0;
        end else begin
            state    <= w_next_state;
            po_cola  <= w_cola;
            po_money <= w_money;
        end
    end

endmodule

// File: tb/tb_complex_fsm.sv
// tb/tb_complex_fsm.sv - directed and model-checked bench for complex_fsm
module tb_complex_fsm;
    import complex_fsm_pkg::*;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic pi_money_one;
    logic pi_money_half;
    logic po_cola;
    logic po_money;

    int total = 0;
    int bad   = 0;

    complex_fsm dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .pi_money_one  (pi_money_one),
        .pi_money_half (pi_money_half),
        .po_cola       (po_cola),
        .po_money      (po_money)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic one, input logic half);
        @(negedge sys_clk);
        sys_rst       = rst;
        pi_money_one  = one;
        pi_money_half = half;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic expect3(input string tag, input logic [4:0] st, input logic cola, input logic money);
        check({tag, ".state"}, {27'd0, dut.state}, {27'd0, st});
        check({tag, ".cola"},  {31'd0, po_cola},   {31'd0, cola});
        check({tag, ".money"}, {31'd0, po_money},  {31'd0, money});
    endtask

    logic [4:0] half_seq [5];
    int credit;
    int cola_cnt;
    int money_cnt;
    int exp_cola_cnt;
    int exp_money_cnt;
    logic exp_cola;
    logic exp_money;
    logic [4:0] enc [5];

    initial begin
        half_seq[0] = HALF; half_seq[1] = ONE; half_seq[2] = ONE_HALF;
        half_seq[3] = TWO;  half_seq[4] = IDLE;
        enc[0] = IDLE; enc[1] = HALF; enc[2] = ONE; enc[3] = ONE_HALF; enc[4] = TWO;

        sys_rst = 1'b1; pi_money_one = 1'b0; pi_money_half = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        expect3("reset", IDLE, 1'b0, 1'b0);

        // Five half coins: 2.5 total, one cola, no change.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1);
            expect3($sformatf("halves%0d", i), half_seq[i], (i == 4), 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        expect3("halves_after", IDLE, 1'b0, 1'b0);

        // Three ones: 3.0 total, cola plus change together.
        step(1'b0, 1'b1, 1'b0); expect3("ones0", ONE,  1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); expect3("ones1", TWO,  1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); expect3("ones2", IDLE, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0); expect3("ones_after", IDLE, 1'b0, 1'b0);

        step(1'b0, 1'b1, 1'b0); expect3("mix0", ONE,      1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1); expect3("mix1", ONE_HALF, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); expect3("mix2", IDLE,     1'b1, 1'b0);

        // Hold at ONE_HALF with no coin, then with both coins at once.
        step(1'b0, 1'b1, 1'b0); expect3("hold_a", ONE,      1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1); expect3("hold_b", ONE_HALF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            expect3($sformatf("hold_idle%0d", i), ONE_HALF, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1);
        expect3("hold_both", ONE_HALF, 1'b0, 1'b0);
        check("pi_money_probe", {30'd0, dut.pi_money}, 32'd3);

        step(1'b0, 1'b0, 1'b1); expect3("to_two", TWO, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0); expect3("rst_at_two", IDLE, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1); expect3("first_after_rst", HALF, 1'b0, 1'b0);

        // Back-to-back purchase: coin right after dispense is credited from IDLE.
        step(1'b0, 1'b1, 1'b0); expect3("b2b0", ONE_HALF, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); expect3("b2b1", IDLE,     1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1); expect3("b2b2", HALF,     1'b0, 1'b0);

        // Random single-coin stream against a credit counter in half units.
        step(1'b1, 1'b0, 1'b0);
        credit = 0; cola_cnt = 0; money_cnt = 0; exp_cola_cnt = 0; exp_money_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            logic coin_one;
            coin_one = 1'($urandom_range(0, 1));
            step(1'b0, coin_one, !coin_one);
            credit   += coin_one ? 2 : 1;
            exp_cola  = 1'b0;
            exp_money = 1'b0;
            if (credit >= 5) begin
                exp_cola  = 1'b1;
                exp_money = (credit == 6);
                credit    = 0;
            end
            exp_cola_cnt  += int'(exp_cola);
            exp_money_cnt += int'(exp_money);
            cola_cnt      += int'(po_cola);
            money_cnt     += int'(po_money);
            expect3($sformatf("rand%0d", i), enc[credit], exp_cola, exp_money);
        end
        check("rand_cola_count",  cola_cnt,  exp_cola_cnt);
        check("rand_money_count", money_cnt, exp_money_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
